storage_port_arbiter: RTL



---
 rtl/storage_pkg.sv | 15 +
 rtl/rr_pick.sv | 37 +++
 rtl/storage_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/storage_pkg.sv
// Shared definitions for the storage port arbiter.
//   NUM_REQ / IDX_W : requester count and index width
//   DEF_AW / DEF_DW : default storage address / data widths
//   fsm_e           : arbiter state (IDLE = no grant held, GRANT = one owner holds the port)
package storage_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int DEF_AW  = 4;
  localparam int DEF_DW  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } fsm_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req_i    : request vector
//   ptr_i    : index with highest priority this cycle
//   mask_i   : requests allowed to win (1 = eligible)
//   valid_o  : some eligible request exists
//   idx_o    : winning index (0 when none)
//   onehot_o : winning index as one-hot (zero when none)
module rr_pick
  import storage_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [NUM_REQ-1:0] onehot_o
);
  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   pos;

  // Walk from the farthest rotation slot back to ptr so the slot closest
  // to ptr is written last and wins.
  always_comb begin
    cand    = req_i & mask_i;
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = ptr_i + IDX_W'(k);
      if (cand[pos]) begin
        valid_o = 1'b1;
        idx_o   = pos;
      end
    end
    onehot_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/storage_port_arbiter.sv
// Round-robin arbiter sharing one storage port among four requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req, addr_i, data_i, we_i : per-requester request level and packed access fields
//   gnt, owner, busy    : registered grant state
//   mem_en, mem_we, mem_addr, mem_wdata : storage port, driven from the owner's live inputs
// States:
//   IDLE  | no grant held, arbitrating from ptr
//   GRANT | owner holds the port for up to MAX_BURST beats
module storage_port_arbiter
  import storage_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] addr_i,
  input  logic [NUM_REQ*DW-1:0] data_i,
  input  logic [NUM_REQ-1:0]    we_i,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [IDX_W-1:0]      owner,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata
);
  localparam int BW = $clog2(MAX_BURST) + 1;

  fsm_e               fsm_q, fsm_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;

  logic               req_own;
  logic               last_beat;
  logic [IDX_W-1:0]   pk_ptr;
  logic [NUM_REQ-1:0] pk_mask;
  logic               pk_valid;
  logic [IDX_W-1:0]   pk_idx;
  logic [NUM_REQ-1:0] pk_onehot;

  assign req_own   = req[owner_q];
  assign last_beat = (beat_q == BW'(MAX_BURST - 1));

  // One picker serves both cases: from IDLE it rotates from ptr over all
  // requests; on release it rotates from owner+1 with the owner masked out.
  assign pk_ptr  = (fsm_q == GRANT) ? owner_q + IDX_W'(1) : ptr_q;
  assign pk_mask = (fsm_q == GRANT) ? ~gnt_q : '1;

  rr_pick u_pick (
    .req_i    (req),
    .ptr_i    (pk_ptr),
    .mask_i   (pk_mask),
    .valid_o  (pk_valid),
    .idx_o    (pk_idx),
    .onehot_o (pk_onehot)
  );

  // A reset cycle never issues a beat, even with a grant still registered.
  assign mem_en    = busy_q & ~rst & req_own;
  assign mem_we    = mem_en & we_i[owner_q];
  assign mem_addr  = mem_en ? addr_i[owner_q*AW +: AW] : '0;
  assign mem_wdata = mem_en ? data_i[owner_q*DW +: DW] : '0;

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

  always_comb begin
    fsm_d   = fsm_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    case (fsm_q)
      IDLE: begin
        if (pk_valid) begin
          owner_d = pk_idx;
          gnt_d   = pk_onehot;
          busy_d  = 1'b1;
          beat_d  = '0;
          fsm_d   = GRANT;
        end
      end
      GRANT: begin
        if (req_own && !last_beat) begin
          beat_d = beat_q + BW'(1);
        end else begin
          ptr_d = owner_q + IDX_W'(1);
          if (pk_valid) begin
            owner_d = pk_idx;
            gnt_d   = pk_onehot;
            beat_d  = '0;
          end else begin
            fsm_d   = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            owner_d = '0;
            beat_d  = '0;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      ptr_q   <= '0;
      beat_q  <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end
endmodule
